// File: rtl/imem_pkg.sv
// Shared constants, the response-entry type and the fetch address-range check
// for the instruction-memory fetch unit.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_ADDR_DEF = 32'h0100_0000;
  localparam logic [31:0] IMEM_NOP_INSTR_DEF = 32'h1111_1111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } imem_rsp_t;

  // Checked at 33 bits so a window that ends at 2^32 cannot wrap around.
  function automatic logic imem_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] span);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < b + span) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Request/response bus between a fetch requester (master) and imem_fetch_unit (slave).
// Both channels: a beat transfers on a rising edge where valid && ready; a raised
// valid and its payload hold until that beat, and ready may change freely.
interface imem_fetch_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Response buffer for imem_fetch_unit: DEPTH entries, in-order, flush clears it.
// Flush wins over a simultaneous push or pop.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  imem_rsp_t                  i_data,
  input  logic                       i_pop,
  output imem_rsp_t                  o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  imem_rsp_t                  r_mem [DEPTH];
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [$clog2(DEPTH+1)-1:0] r_count;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: 1-cycle read of an on-chip instruction memory with an
// in-order response buffer. Define IMEM_LOAD_PORT_EN to add the ld_* write port.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR_DEF,
  parameter logic [31:0] NOP_INSTR = IMEM_NOP_INSTR_DEF,
  parameter int          RSP_DEPTH = 3,
  parameter              INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
`ifdef IMEM_LOAD_PORT_EN
  input  logic                         ld_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
  input  logic [31:0]                  ld_data,
`endif
  imem_fetch_unit_if.slave             bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [31:0] r_mem [MEM_DEPTH];
  logic        r_if_vld;
  imem_rsp_t   r_if;
  imem_rsp_t   w_head;
  imem_rsp_t   w_out;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_fifo_empty;
  logic          w_addr_ok;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_rsp_fire;
  logic          w_fifo_push;
  logic          w_fifo_pop;

`ifdef IMEM_LOAD_PORT_EN
  // Not gated by rst/flush; the read below sees the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end
`endif

  assign w_addr_ok = imem_addr_ok(bus.req_addr, BASE_ADDR, 33'(4 * MEM_DEPTH));
  assign w_idx     = AW'((bus.req_addr - BASE_ADDR) >> 2);

  // Occupancy counts the read still in flight so the buffer can never overflow.
  assign w_fifo_empty  = (w_count == '0);
  assign w_occ         = {1'b0, w_count} + (CW + 1)'(r_if_vld);
  assign bus.req_ready = !rst && !flush && (w_occ < (CW + 1)'(RSP_DEPTH));
  assign w_accept      = bus.req_valid && bus.req_ready;

  // An empty buffer exposes the in-flight read directly, giving 1-cycle latency.
  assign bus.rsp_valid = !w_fifo_empty || r_if_vld;
  assign w_out         = w_fifo_empty ? r_if : w_head;
  assign w_rsp_fire    = bus.rsp_valid && bus.rsp_ready;
  assign w_fifo_pop    = w_rsp_fire && !w_fifo_empty;
  assign w_fifo_push   = r_if_vld && !(w_rsp_fire && w_fifo_empty);

  assign bus.rsp_instr = w_out.instr;
  assign bus.rsp_addr  = w_out.addr;
  assign bus.rsp_err   = w_out.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_vld <= 1'b0;
      r_if     <= '{instr: NOP_INSTR, addr: 32'h0, err: 1'b0};
    end else if (flush) begin
      r_if_vld <= 1'b0;
    end else begin
      r_if_vld <= w_accept;
      if (w_accept) begin
        r_if.addr <= bus.req_addr;
        r_if.err  <= !w_addr_ok;
        if (w_addr_ok) r_if.instr <= r_mem[w_idx];
        else           r_if.instr <= NOP_INSTR;
      end
    end
  end

  imem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_fifo_push),
    .i_data  (r_if),
    .i_pop   (w_fifo_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule
